// File: rtl/clock_time_seq.sv
// Purpose: HH:MM:SS BCD time-of-day counter with a seconds prescaler and per-digit carry FSM.
// Latency: a request sampled at edge N is granted at N+1; the first digit updates at N+2.
// Backpressure: none; requests pend in one-deep flags and repeats of a pending request coalesce.
module clock_time_seq #(
  parameter int CORE_CLOCK = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       adj_sec,
  input  logic       adj_min,
  input  logic       adj_hrs,
  output logic [3:0] sec_u,
  output logic [2:0] sec_d,
  output logic [3:0] min_u,
  output logic [2:0] min_d,
  output logic [3:0] hrs_u,
  output logic [1:0] hrs_d,
  output logic [3:0] color_offset,
  output logic       sec_tick,
  output logic       busy
);

  localparam int            PW      = (CORE_CLOCK > 1) ? $clog2(CORE_CLOCK) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(CORE_CLOCK - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SU   = 3'd1,
    SD   = 3'd2,
    MU   = 3'd3,
    MD   = 3'd4,
    HR   = 3'd5
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [PW-1:0] ps_cnt;
  logic          ps_wrap;

  logic          tick_p;
  logic          sec_p;
  logic          min_p;
  logic          hrs_p;

  logic          grant_tick;
  logic          grant_sec;
  logic          grant_min;
  logic          grant_hrs;

  logic [3:0]    sec_u_nxt;
  logic [2:0]    sec_d_nxt;
  logic [3:0]    min_u_nxt;
  logic [2:0]    min_d_nxt;
  logic [3:0]    hrs_u_nxt;
  logic [1:0]    hrs_d_nxt;
  logic [3:0]    color_nxt;

  assign ps_wrap = run && (ps_cnt == PS_LAST);
  assign busy    = (state != IDLE);

  // Seconds prescaler: counts while run is high, wraps at CORE_CLOCK-1 and emits a one-cycle tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps_cnt   <= '0;
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= ps_wrap;
      if (run) begin
        ps_cnt <= ps_wrap ? '0 : ps_cnt + PW'(1);
      end
    end
  end

  // Pending request flags: a new request in the same cycle as its grant wins over the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_p <= 1'b0;
      sec_p  <= 1'b0;
      min_p  <= 1'b0;
      hrs_p  <= 1'b0;
    end else begin
      tick_p <= ps_wrap | (tick_p & ~grant_tick);
      sec_p  <= adj_sec | (sec_p  & ~grant_sec);
      min_p  <= adj_min | (min_p  & ~grant_min);
      hrs_p  <= adj_hrs | (hrs_p  & ~grant_hrs);
    end
  end

  // State and digit registers; digits only move when the FSM visits their own state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sec_u        <= '0;
      sec_d        <= '0;
      min_u        <= '0;
      min_d        <= '0;
      hrs_u        <= '0;
      hrs_d        <= '0;
      color_offset <= '0;
    end else begin
      state        <= state_nxt;
      sec_u        <= sec_u_nxt;
      sec_d        <= sec_d_nxt;
      min_u        <= min_u_nxt;
      min_d        <= min_d_nxt;
      hrs_u        <= hrs_u_nxt;
      hrs_d        <= hrs_d_nxt;
      color_offset <= color_nxt;
    end
  end

  // Arbiter plus carry chain: IDLE grants by fixed priority, each digit state increments and
  // either carries into the next digit state or returns to IDLE.
  always_comb begin
    state_nxt  = state;
    grant_tick = 1'b0;
    grant_sec  = 1'b0;
    grant_min  = 1'b0;
    grant_hrs  = 1'b0;
    sec_u_nxt  = sec_u;
    sec_d_nxt  = sec_d;
    min_u_nxt  = min_u;
    min_d_nxt  = min_d;
    hrs_u_nxt  = hrs_u;
    hrs_d_nxt  = hrs_d;
    color_nxt  = color_offset;

    case (state)
      IDLE: begin
        if (tick_p) begin
          grant_tick = 1'b1;
          state_nxt  = SU;
        end else if (sec_p) begin
          grant_sec  = 1'b1;
          state_nxt  = SU;
        end else if (min_p) begin
          grant_min  = 1'b1;
          state_nxt  = MU;
        end else if (hrs_p) begin
          grant_hrs  = 1'b1;
          state_nxt  = HR;
        end
      end

      SU: begin
        if (sec_u == 4'd9) begin
          sec_u_nxt = 4'd0;
          state_nxt = SD;
        end else begin
          sec_u_nxt = sec_u + 4'd1;
          state_nxt = IDLE;
        end
      end

      SD: begin
        if (sec_d == 3'd5) begin
          sec_d_nxt = 3'd0;
          state_nxt = MU;
        end else begin
          sec_d_nxt = sec_d + 3'd1;
          state_nxt = IDLE;
        end
      end

      MU: begin
        color_nxt = color_offset + 4'd1;
        if (min_u == 4'd9) begin
          min_u_nxt = 4'd0;
          state_nxt = MD;
        end else begin
          min_u_nxt = min_u + 4'd1;
          state_nxt = IDLE;
        end
      end

      MD: begin
        if (min_d == 3'd5) begin
          min_d_nxt = 3'd0;
          state_nxt = HR;
        end else begin
          min_d_nxt = min_d + 3'd1;
          state_nxt = IDLE;
        end
      end

      HR: begin
        if (hrs_d == 2'd2 && hrs_u == 4'd3) begin
          hrs_d_nxt = 2'd0;
          hrs_u_nxt = 4'd0;
        end else if (hrs_u == 4'd9) begin
          hrs_u_nxt = 4'd0;
          hrs_d_nxt = hrs_d + 2'd1;
        end else begin
          hrs_u_nxt = hrs_u + 4'd1;
        end
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_clock_time_seq.sv
// Purpose: directed self-checking bench for clock_time_seq with a 10-cycle second.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled at the same point.
// Backpressure: not applicable; adjust pulses are spaced to let each carry chain finish.
module tb_clock_time_seq;

  logic       clk;
  logic       reset;
  logic       run;
  logic       adj_sec;
  logic       adj_min;
  logic       adj_hrs;
  logic [3:0] sec_u;
  logic [2:0] sec_d;
  logic [3:0] min_u;
  logic [2:0] min_d;
  logic [3:0] hrs_u;
  logic [1:0] hrs_d;
  logic [3:0] color_offset;
  logic       sec_tick;
  logic       busy;

  logic [19:0] cur_time;
  int          total;
  int          bad;
  int          tick_cnt;
  int          busy_cnt;
  logic        found;

  clock_time_seq #(.CORE_CLOCK(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .adj_sec      (adj_sec),
    .adj_min      (adj_min),
    .adj_hrs      (adj_hrs),
    .sec_u        (sec_u),
    .sec_d        (sec_d),
    .min_u        (min_u),
    .min_d        (min_d),
    .hrs_u        (hrs_u),
    .hrs_d        (hrs_d),
    .color_offset (color_offset),
    .sec_tick     (sec_tick),
    .busy         (busy)
  );

  assign cur_time = {hrs_d, hrs_u, min_d, min_u, sec_d, sec_u};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] bcd(input int hh, input int mm, input int ss);
    return {2'(hh / 10), 4'(hh % 10), 3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick_clk;
    @(posedge clk);
    #1;
    if (sec_tick) tick_cnt++;
  endtask

  task automatic pulse_adj(input int which);
    case (which)
      0:       adj_sec = 1'b1;
      1:       adj_min = 1'b1;
      default: adj_hrs = 1'b1;
    endcase
    tick_clk;
    adj_sec = 1'b0;
    adj_min = 1'b0;
    adj_hrs = 1'b0;
    repeat (7) tick_clk;
  endtask

  task automatic preset(input int hh, input int mm, input int ss);
    for (int i = 0; i < hh; i++) pulse_adj(2);
    for (int i = 0; i < mm; i++) pulse_adj(1);
    for (int i = 0; i < ss; i++) pulse_adj(0);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    tick_cnt = 0;
    reset    = 1'b1;
    run      = 1'b1;
    adj_sec  = 1'b0;
    adj_min  = 1'b0;
    adj_hrs  = 1'b0;

    // Reset state, with a request pulse coincident with reset that must be dropped.
    repeat (3) tick_clk;
    chk("rst_time", cur_time, 20'h0);
    chk("rst_color", color_offset, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tick", sec_tick, 0);
    adj_sec = 1'b1;
    tick_clk;
    adj_sec = 1'b0;
    reset   = 1'b0;

    // First second: tick on cycle 10, busy only on cycle 11, sec_u=1 on cycle 12.
    for (int k = 1; k <= 12; k++) begin
      tick_clk;
      chk($sformatf("tick_c%0d", k), sec_tick, (k == 10) ? 1 : 0);
      chk($sformatf("busy_c%0d", k), busy, (k == 11) ? 1 : 0);
    end
    chk("first_sec", cur_time, bcd(0, 0, 1));

    // Hour adjust walks all 24 hours with the prescaler held.
    run   = 1'b0;
    reset = 1'b1;
    tick_clk;
    reset    = 1'b0;
    tick_clk;
    tick_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      pulse_adj(2);
      if (i == 9)  chk("hrs_10", cur_time, bcd(10, 0, 0));
      if (i == 22) chk("hrs_23", cur_time, bcd(23, 0, 0));
    end
    chk("hrs_wrap", cur_time, bcd(0, 0, 0));
    chk("hrs_no_tick", tick_cnt, 0);
    chk("hrs_color", color_offset, 0);

    // Full rollover from 23:59:59 driven by a tick.
    preset(23, 59, 59);
    chk("preset_235959", cur_time, bcd(23, 59, 59));
    chk("preset_color", color_offset, 11);
    run   = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick_clk;
      if (sec_tick) found = 1'b1;
    end
    run = 1'b0;
    chk("roll_tick_seen", found, 1);
    for (int c = 0; c < 8; c++) begin
      tick_clk;
      chk($sformatf("roll_busy_%0d", c), busy, (c < 5) ? 1 : 0);
    end
    chk("roll_time", cur_time, bcd(0, 0, 0));
    chk("roll_color", color_offset, 12);

    // Reset in the middle of a rollover carry, with a pending hour request queued.
    preset(23, 59, 59);
    chk("preset2_color", color_offset, 7);
    adj_sec = 1'b1;
    tick_clk;
    adj_sec = 1'b0;
    adj_hrs = 1'b1;
    tick_clk;
    adj_hrs = 1'b0;
    tick_clk;
    tick_clk;
    tick_clk;
    chk("md_busy", busy, 1);
    chk("md_min_u", min_u, 0);
    reset   = 1'b1;
    adj_min = 1'b1;
    tick_clk;
    reset   = 1'b0;
    adj_min = 1'b0;
    chk("mdrst_time", cur_time, 20'h0);
    chk("mdrst_color", color_offset, 0);
    chk("mdrst_busy", busy, 0);
    chk("mdrst_tick", sec_tick, 0);
    busy_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick_clk;
      if (busy) busy_cnt++;
    end
    chk("mdrst_no_stale", busy_cnt, 0);
    chk("mdrst_time_after", cur_time, 20'h0);

    // Adjust and tick sampled on the same edge are served one after the other.
    preset(0, 0, 58);
    chk("preset_58", cur_time, bcd(0, 0, 58));
    run = 1'b1;
    repeat (9) tick_clk;
    adj_sec = 1'b1;
    tick_clk;
    adj_sec = 1'b0;
    run     = 1'b0;
    chk("both_tick", sec_tick, 1);
    repeat (12) tick_clk;
    chk("both_time", cur_time, bcd(0, 1, 0));
    chk("both_color", color_offset, 1);

    // Two back-to-back minute pulses while busy count once.
    preset(0, 0, 9);
    chk("preset_0109", cur_time, bcd(0, 1, 9));
    adj_sec = 1'b1;
    tick_clk;
    adj_sec = 1'b0;
    tick_clk;
    adj_min = 1'b1;
    chk("coal_busy_a", busy, 1);
    tick_clk;
    chk("coal_busy_b", busy, 1);
    tick_clk;
    adj_min = 1'b0;
    repeat (8) tick_clk;
    chk("coal_time", cur_time, bcd(0, 2, 10));
    chk("coal_color", color_offset, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
